// File: rtl/bcd_digit_converter.sv
// -----------------------------------------------------------------------------
// bcd_digit_converter
//
// Sequential binary-to-BCD converter (shift-and-add-3 / "double dabble").
// Takes the accumulator value from the processor, converts it one bit per
// clock and presents registered decimal digits plus a leading-zero blank
// mask to the seven-segment display controller. The outputs only change on
// the cycle a conversion finishes, so the display never shows partial digits.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   in_valid   in_data is valid this cycle
//   in_data    unsigned binary value to convert (WIDTH bits)
//   in_ready   high only while idle; a value is accepted when in_valid is also high
//   busy       high while a conversion is in progress (SHIFT and DONE)
//   out_valid  one-cycle pulse: bcd/blank were updated this cycle
//   bcd        registered digits, [3:0] = ones, [7:4] = tens, ...
//   blank      bit i = 1 means digit i is a leading zero; bit 0 is always 0
//
// The integrator must keep 10^DIGITS > 2^WIDTH - 1; overflow is not flagged.
// -----------------------------------------------------------------------------
module bcd_digit_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int CW = $clog2(WIDTH + 1);

    // Reset/idle mask shows a single "0": every digit blanked except the ones.
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [WIDTH-1:0]       r_bin;        // binary operand, shifted out MSB first
    logic [4*DIGITS-1:0]    r_scratch;    // BCD digits under construction
    logic [CW-1:0]          r_count;      // shifts remaining
    logic [4*DIGITS-1:0]    r_bcd;
    logic [DIGITS-1:0]      r_blank;
    logic                   r_out_valid;

    logic [4*DIGITS-1:0]    w_adj;        // scratch after the add-3 correction
    logic [DIGITS-1:0]      w_blank;
    logic                   w_run_zero;
    logic                   w_last_shift;

    assign w_last_shift = (r_count == CW'(1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top of a combinational block keeps
    // every path driven, so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)     w_next = SHIFT;
            SHIFT:   if (w_last_shift) w_next = DONE;
            DONE:                      w_next = IDLE;
            default:                   w_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready = (r_state == IDLE);
        busy     = (r_state != IDLE);
    end

    // -------------------------------------------------------------------------
    // Add-3 correction: any digit >= 5 becomes >= 8 so the following left
    // shift carries it into the next digit. Digits are independent 4-bit sums.
    // -------------------------------------------------------------------------
    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Leading-zero mask: walk from the top digit down; a digit is blank while
    // it and everything above it is zero. The ones digit is never blanked.
    // -------------------------------------------------------------------------
    always_comb begin
        w_blank    = '0;
        w_run_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_run_zero = w_run_zero && (r_scratch[4*i +: 4] == 4'd0);
            w_blank[i] = w_run_zero;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin       <= '0;
            r_scratch   <= '0;
            r_count     <= '0;
            r_bcd       <= '0;
            r_blank     <= BLANK_RST;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin     <= in_data;
                        r_scratch <= '0;
                        r_count   <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    // Binary MSB moves into the scratch LSB.
                    {r_scratch, r_bin} <= {w_adj[4*DIGITS-2:0], r_bin, 1'b0};
                    r_count            <= r_count - CW'(1);
                end
                DONE: begin
                    r_bcd       <= r_scratch;
                    r_blank     <= w_blank;
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign bcd       = r_bcd;
    assign blank     = r_blank;

endmodule

// File: tb/tb_bcd_digit_converter.sv
module tb_bcd_digit_converter;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        busy;
    logic        out_valid;
    logic [11:0] bcd;
    logic [2:0]  blank;

    typedef struct {
        logic [11:0] bcd;
        logic [2:0]  blank;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [11:0] held_bcd;
    logic [2:0]  held_blank;

    bcd_digit_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .bcd       (bcd),
        .blank     (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] model_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic logic [2:0] model_blank(input int v);
        logic h_zero, t_zero;
        h_zero = (v / 100) == 0;
        t_zero = ((v / 10) % 10) == 0;
        return {h_zero, h_zero && t_zero, 1'b0};
    endfunction

    // Present a value and wait (bounded) for the edge that accepts it; the
    // expected result is pushed at that point. Called and returns at a negedge.
    task automatic send(input logic [7:0] v, input logic [11:0] e_bcd,
                        input logic [2:0] e_blank, input bit hold, output int acc);
        exp_t e;
        bit   ok;
        ok       = 1'b0;
        acc      = -1;
        in_data  = v;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (in_ready === 1'b1) begin
                ok      = 1'b1;
                acc     = cyc + 1;
                e.bcd   = e_bcd;
                e.blank = e_blank;
                e.acc   = acc;
                sb_q.push_back(e);
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 32'(ok), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            if (!hold) in_valid = 1'b0;
        end
    endtask

    // Monitor: flush on reset, pop and compare on out_valid, otherwise the
    // registered outputs must hold the last delivered result.
    initial begin
        logic rst_at_edge;
        exp_t e;
        forever begin
            @(posedge clk);
            rst_at_edge = reset;
            @(negedge clk);
            if (rst_at_edge) begin
                sb_q.delete();
                held_bcd   = 12'h000;
                held_blank = 3'b110;
            end
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("bcd", 32'(bcd), 32'(e.bcd));
                    check("blank", 32'(blank), 32'(e.blank));
                    check("latency", 32'(cyc - e.acc), 32'd9);
                    held_bcd   = e.bcd;
                    held_blank = e.blank;
                end
            end else begin
                check("hold_bcd", 32'(bcd), 32'(held_bcd));
                check("hold_blank", 32'(blank), 32'(held_blank));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, a1, a2;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bcd", 32'(bcd), 32'h000);
        check("rst_blank", 32'(blank), 32'b110);

        // Zero: in_ready must drop the cycle after accept
        send(8'd0, 12'h000, 3'b110, 1'b0, a0);
        check("in_ready_drop", 32'(in_ready), 32'd0);
        check("busy_rise", 32'(busy), 32'd1);

        // Directed values
        send(8'd255, 12'h255, 3'b000, 1'b0, a0);
        send(8'd9,   12'h009, 3'b110, 1'b0, a0);
        send(8'd100, 12'h100, 3'b000, 1'b0, a0);
        send(8'd10,  12'h010, 3'b100, 1'b0, a0);

        // in_valid held continuously: accepts spaced by a full conversion
        send(8'd37,  12'h037, 3'b100, 1'b1, a1);
        send(8'd200, 12'h200, 3'b000, 1'b0, a2);
        check("accept_spacing", 32'(a2 - a1), 32'd10);

        // New data pulsed while busy must be ignored
        send(8'd123, 12'h123, 3'b000, 1'b0, a0);
        @(negedge clk);
        in_data  = 8'd45;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;

        // Reset during the 4th SHIFT cycle aborts the conversion
        send(8'd255, 12'h255, 3'b000, 1'b0, a0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_bcd", 32'(bcd), 32'h000);
        check("abort_blank", 32'(blank), 32'b110);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        send(8'd58, 12'h058, 3'b100, 1'b0, a0);

        // Full sweep, back-to-back
        for (int v = 0; v < 256; v++) begin
            send(8'(v), model_bcd(v), model_blank(v), 1'b1, a0);
        end
        in_valid = 1'b0;

        for (int i = 0; i < 40; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("drain", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
